// File: rtl/stage_pipe_skid_if.sv
// Handshake bundle between two CPU stages: upstream entry (in_*) and downstream entry (out_*).
// The stage itself uses the slave modport; the driving side (stimulus/neighbour stages) uses master.
interface stage_pipe_skid_if #(
    parameter int DATA_W = 223,
    parameter int PC_W   = 32,
    parameter int EXC_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [PC_W-1:0]   in_pc;
    logic [EXC_W-1:0]  in_exc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;
    logic [EXC_W-1:0]  out_exc;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_data, in_pc, in_exc, out_ready,
        input  in_ready, out_valid, out_data, out_pc, out_exc, occupancy
    );

    modport slave (
        input  in_valid, in_data, in_pc, in_exc, out_ready,
        output in_ready, out_valid, out_data, out_pc, out_exc, occupancy
    );
endinterface

// File: rtl/stage_pipe_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer (main slot M, skid slot S).
// Optional macro STAGE_PIPE_BUBBLE_ZERO_EN clears payload of slots that become invalid.
//
// state | meaning
// EMPTY | no entry held, in_ready=1
// ONE   | M holds the head entry, S free, in_ready=1
// TWO   | M and S both hold entries, in_ready=0
module stage_pipe_skid #(
    parameter int          DATA_W  = 223,
    parameter int          PC_W    = 32,
    parameter int          EXC_W   = 32,
    parameter int unsigned EXC_NON = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    stage_pipe_skid_if.slave     bus
);
    localparam logic [EXC_W-1:0] EXC_NONE = EXC_W'(EXC_NON);

    // Encoding keeps mv in bit 0 and sv in bit 1, so (0,1) has no state.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t state, state_nxt;

    logic              mv, sv, push, pop;
    logic              load_m_in, load_s_in, move_s;
    logic [DATA_W-1:0] m_data, s_data;
    logic [PC_W-1:0]   m_pc, s_pc;
    logic [EXC_W-1:0]  m_exc, s_exc;
`ifdef STAGE_PIPE_BUBBLE_ZERO_EN
    logic              clr_m, clr_s;
`endif

    assign mv   = state[0];
    assign sv   = state[1];
    assign push = bus.in_valid & ~sv;
    assign pop  = mv & bus.out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= EMPTY;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_m_in = 1'b0;
        load_s_in = 1'b0;
        move_s    = 1'b0;
`ifdef STAGE_PIPE_BUBBLE_ZERO_EN
        clr_m     = 1'b0;
        clr_s     = 1'b0;
`endif
        if (flush) begin
            state_nxt = EMPTY;
`ifdef STAGE_PIPE_BUBBLE_ZERO_EN
            clr_m     = 1'b1;
            clr_s     = 1'b1;
`endif
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        load_m_in = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        load_m_in = 1'b1;
                    end else if (push) begin
                        load_s_in = 1'b1;
                        state_nxt = TWO;
                    end else if (pop) begin
                        state_nxt = EMPTY;
`ifdef STAGE_PIPE_BUBBLE_ZERO_EN
                        clr_m     = 1'b1;
`endif
                    end
                end
                TWO: begin
                    if (pop) begin
                        move_s    = 1'b1;
                        state_nxt = ONE;
`ifdef STAGE_PIPE_BUBBLE_ZERO_EN
                        clr_s     = 1'b1;
`endif
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_data <= '0;
            m_pc   <= '0;
            m_exc  <= EXC_NONE;
            s_data <= '0;
            s_pc   <= '0;
            s_exc  <= EXC_NONE;
        end else begin
            if (load_m_in) begin
                m_data <= bus.in_data;
                m_pc   <= bus.in_pc;
                m_exc  <= bus.in_exc;
            end else if (move_s) begin
                m_data <= s_data;
                m_pc   <= s_pc;
                m_exc  <= s_exc;
`ifdef STAGE_PIPE_BUBBLE_ZERO_EN
            end else if (clr_m) begin
                m_data <= '0;
                m_pc   <= '0;
                m_exc  <= EXC_NONE;
`endif
            end
            if (load_s_in) begin
                s_data <= bus.in_data;
                s_pc   <= bus.in_pc;
                s_exc  <= bus.in_exc;
`ifdef STAGE_PIPE_BUBBLE_ZERO_EN
            end else if (clr_s) begin
                s_data <= '0;
                s_pc   <= '0;
                s_exc  <= EXC_NONE;
`endif
            end
        end
    end

    // All outputs derive from flops only; no combinational path from out_ready to in_ready.
    assign bus.in_ready  = ~sv;
    assign bus.out_valid = mv;
    assign bus.out_data  = m_data;
    assign bus.out_pc    = m_pc;
    assign bus.out_exc   = mv ? m_exc : EXC_NONE;
    assign bus.occupancy = {1'b0, mv} + {1'b0, sv};
endmodule

// File: tb/tb_stage_pipe_skid.sv
// Bench for stage_pipe_skid: directed vector table, hand-written corner sequences, and random traffic
// compared against a FIFO-queue reference model.
module tb_stage_pipe_skid;
    localparam int DATA_W = 223;
    localparam int PC_W   = 32;
    localparam int EXC_W  = 32;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
        logic [EXC_W-1:0]  exc;
    } entry_t;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] exc;
        logic        rdy;
        logic        fl;
        logic        e_ov;
        logic        e_ir;
        logic [1:0]  e_occ;
        logic [31:0] e_pc;
        logic [31:0] e_exc;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    entry_t q[$];
    vec_t   vt[14];

    stage_pipe_skid_if #(.DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W)) bus ();

    stage_pipe_skid #(.DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W), .EXC_NON(0)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mk_data(input logic [31:0] k);
        logic [DATA_W-1:0] d;
        d = '0;
        d[31:0] = k;
        d[DATA_W-1 -: 32] = ~k;
        d[120 +: 32] = k ^ 32'h5A5A_1234;
        return d;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: the stage is a 2-deep FIFO; occupancy is its size, head is what the outputs show.
    task automatic model_update();
        entry_t e;
        int     sz;
        if (flush) begin
            q.delete();
        end else begin
            sz = q.size();
            if (sz > 0 && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && sz < 2) begin
                e.data = bus.in_data;
                e.pc   = bus.in_pc;
                e.exc  = bus.in_exc;
                q.push_back(e);
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out_valid"}, 256'(bus.out_valid), 256'(q.size() > 0));
        chk({tag, ".in_ready"},  256'(bus.in_ready),  256'(q.size() < 2));
        chk({tag, ".occupancy"}, 256'(bus.occupancy), 256'(q.size()));
        if (q.size() > 0) begin
            chk({tag, ".out_pc"},   256'(bus.out_pc),   256'(q[0].pc));
            chk({tag, ".out_data"}, 256'(bus.out_data), 256'(q[0].data));
            chk({tag, ".out_exc"},  256'(bus.out_exc),  256'(q[0].exc));
        end else begin
            chk({tag, ".out_exc_bubble"}, 256'(bus.out_exc), 256'(0));
`ifdef STAGE_PIPE_BUBBLE_ZERO_EN
            chk({tag, ".out_pc_bubble"},   256'(bus.out_pc),   256'(0));
            chk({tag, ".out_data_bubble"}, 256'(bus.out_data), 256'(0));
`endif
        end
    endtask

    // Called just after a falling edge: apply inputs, take one rising edge, return at next falling edge.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] exc,
                        input logic [DATA_W-1:0] data, input logic rdy, input logic fl);
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_exc    = exc;
        bus.in_data   = data;
        bus.out_ready = rdy;
        flush         = fl;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        // Test 2: streaming with out_ready=1
        vt[0]  = '{1'b1, 32'h100, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h100, 32'h0};
        vt[1]  = '{1'b1, 32'h104, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h104, 32'h0};
        vt[2]  = '{1'b1, 32'h108, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h108, 32'h0};
        vt[3]  = '{1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,   32'h0};
        // Test 3: backpressure fills skid, C held upstream, then drain in order
        vt[4]  = '{1'b1, 32'h200, 32'h0C, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h200, 32'h0C};
        vt[5]  = '{1'b1, 32'h204, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h200, 32'h0C};
        vt[6]  = '{1'b1, 32'h208, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h200, 32'h0C};
        vt[7]  = '{1'b1, 32'h208, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h204, 32'h0};
        vt[8]  = '{1'b1, 32'h208, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h208, 32'h0};
        vt[9]  = '{1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,   32'h0};
        // Test 4: flush while full with a same-cycle push of D
        vt[10] = '{1'b1, 32'h300, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h300, 32'h0};
        vt[11] = '{1'b1, 32'h304, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h300, 32'h0};
        vt[12] = '{1'b1, 32'h3FF, 32'h7,  1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0,   32'h0};
        vt[13] = '{1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,   32'h0};

        resetn        = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_exc    = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #3;
        chk("reset.out_valid", 256'(bus.out_valid), 256'(0));
        chk("reset.in_ready",  256'(bus.in_ready),  256'(1));
        chk("reset.occupancy", 256'(bus.occupancy), 256'(0));
        chk("reset.out_exc",   256'(bus.out_exc),   256'(0));
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(vt[i].iv, vt[i].pc, vt[i].exc, mk_data(vt[i].pc), vt[i].rdy, vt[i].fl);
            chk($sformatf("vec%0d.out_valid", i), 256'(bus.out_valid), 256'(vt[i].e_ov));
            chk($sformatf("vec%0d.in_ready", i),  256'(bus.in_ready),  256'(vt[i].e_ir));
            chk($sformatf("vec%0d.occupancy", i), 256'(bus.occupancy), 256'(vt[i].e_occ));
            chk($sformatf("vec%0d.out_exc", i),   256'(bus.out_exc),   256'(vt[i].e_exc));
            if (vt[i].e_ov) begin
                chk($sformatf("vec%0d.out_pc", i),   256'(bus.out_pc),   256'(vt[i].e_pc));
                chk($sformatf("vec%0d.out_data", i), 256'(bus.out_data), 256'(mk_data(vt[i].e_pc)));
            end
            check_model($sformatf("vec%0d", i));
        end

        // Test 5: exception entry popped to empty leaves a clean bubble
        step(1'b1, 32'h100, 32'h0C, mk_data(32'h100), 1'b0, 1'b0);
        chk("exc.held", 256'(bus.out_exc), 256'(32'h0C));
        step(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);
        chk("exc.bubble_exc", 256'(bus.out_exc), 256'(0));
`ifdef STAGE_PIPE_BUBBLE_ZERO_EN
        chk("exc.bubble_pc",   256'(bus.out_pc),   256'(0));
        chk("exc.bubble_data", 256'(bus.out_data), 256'(0));
`else
        chk("exc.stale_pc", 256'(bus.out_pc), 256'(32'h100));
`endif

        // Test 6: ten cycles of simultaneous push and pop in ONE
        step(1'b1, 32'h400, 32'h0, mk_data(32'h400), 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 32'h400 + 32'(4 * i), 32'h0, mk_data(32'h400 + 32'(4 * i)), 1'b1, 1'b0);
            chk($sformatf("pp%0d.occupancy", i), 256'(bus.occupancy), 256'(1));
            chk($sformatf("pp%0d.in_ready", i),  256'(bus.in_ready),  256'(1));
            chk($sformatf("pp%0d.out_pc", i),    256'(bus.out_pc),    256'(32'h400 + 32'(4 * i)));
        end

        // Test 1: async reset while full
        step(1'b1, 32'h500, 32'h9, mk_data(32'h500), 1'b0, 1'b0);
        step(1'b1, 32'h504, 32'h0, mk_data(32'h504), 1'b0, 1'b0);
        chk("prefill.occupancy", 256'(bus.occupancy), 256'(2));
        #2;
        resetn = 1'b0;
        #1;
        q.delete();
        chk("async_rst.out_valid", 256'(bus.out_valid), 256'(0));
        chk("async_rst.in_ready",  256'(bus.in_ready),  256'(1));
        chk("async_rst.occupancy", 256'(bus.occupancy), 256'(0));
        chk("async_rst.out_exc",   256'(bus.out_exc),   256'(0));
        @(negedge clk);
        resetn = 1'b1;
        step(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);
        check_model("post_rst");

        // Random traffic against the FIFO model
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] rpc;
            logic [31:0] rexc;
            rpc  = $urandom;
            rexc = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            step($urandom_range(0, 3) != 0, rpc, rexc, mk_data($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
            check_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
